dptr_pipe: RTL and testbench

- Parametrised, 3-stage pipelined R-type datapath: register file, ALU and write-back.
- Accepts one 32-bit MIPS R-format instruction per cycle over a valid/ready handshake and executes it.
- Reports rd, result, zero flag and error per instruction over a second valid/ready handshake.
- Successor to the combinational R-type datapath: adds a clock, pipelining, operand forwarding, backpressure and illegal-instruction reporting.

---
 rtl/dptr_pipe.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_dptr_pipe.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dptr_pipe.sv
// rtl/dptr_pipe.sv - pipelined R-type datapath with forwarding and backpressure
//
// Purpose:
//   This datapath executes one MIPS R-format instruction per cycle. It has an
//   input register, an ID stage (decode and register read with forwarding), an
//   EX stage (ALU), an EX result register and a WB output register. An
//   instruction accepted at edge N is presented at edge N+3.
//   A single stall condition (out_valid && !out_ready) freezes every stage.
//   The architectural register file commits from the WB register on the
//   output transfer edge.
//
// Optional feature:
//   DPTR_SHIFT_EN - adds sll / srl / sra (funct 000000 / 000010 / 000011).
//   If the macro is undefined, those functs are reported as illegal.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   instruction valid
//   in_ready   datapath accepts an instruction this cycle
//   instr      [31:26] op, [25:21] rs, [20:16] rt, [15:11] rd, [10:6] shamt, [5:0] funct
//   out_valid  result present
//   out_ready  consumer accepts the result
//   out_rd     destination register of the result
//   out_data   ALU result (0 when illegal)
//   zflag      out_data == 0
//   err        instruction was illegal

module dptr_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_N  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_rd,
  output logic [DATA_W-1:0] out_data,
  output logic              zflag,
  output logic              err
);

  localparam int         IDX_W   = (REG_N > 1) ? $clog2(REG_N) : 1;
  localparam logic [5:0] REG_N_L = 6'(REG_N);

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010;
`ifdef DPTR_SHIFT_EN
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_SRA = 6'b000011;
`endif

  // Global pipeline enable: every stage moves together, or none moves.
  logic advance;
  logic out_fire;

  // Input register
  logic        id_valid_q;
  logic [31:0] id_instr_q;

  // ID decode
  logic [5:0]        id_op;
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic [4:0]        id_rd;
  logic [5:0]        id_funct;
  logic              id_legal;
  logic              id_wen;
  logic [DATA_W-1:0] id_a;
  logic [DATA_W-1:0] id_b;

  // EX stage register
  logic              ex_valid_q;
  logic [DATA_W-1:0] ex_a_q;
  logic [DATA_W-1:0] ex_b_q;
  logic [5:0]        ex_funct_q;
  logic [4:0]        ex_rd_q;
  logic              ex_err_q;
  logic              ex_wen_q;
`ifdef DPTR_SHIFT_EN
  logic [4:0]        ex_shamt_q;
`endif
  logic [DATA_W-1:0] ex_res;
  logic              ex_z;

  // EX result register
  logic              wb_valid_q;
  logic [DATA_W-1:0] wb_data_q;
  logic              wb_z_q;
  logic [4:0]        wb_rd_q;
  logic              wb_err_q;
  logic              wb_wen_q;

  // WB output register
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_z_q;
  logic [4:0]        out_rd_q;
  logic              out_err_q;
  logic              out_wen_q;

  // Architectural registers; entry 0 is reset to 0 and is never written.
  logic [DATA_W-1:0] rf_q [REG_N];

  assign advance  = !(out_valid_q && !out_ready);
  assign in_ready = advance;
  assign out_fire = out_valid_q && out_ready;

  // ---------------------------------------------------------------- input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid_q <= 1'b0;
      id_instr_q <= '0;
    end else if (advance) begin
      id_valid_q <= in_valid;
      if (in_valid) begin
        id_instr_q <= instr;
      end
    end
  end

  // ------------------------------------------------------------------- ID
  assign id_op    = id_instr_q[31:26];
  assign id_rs    = id_instr_q[25:21];
  assign id_rt    = id_instr_q[20:16];
  assign id_rd    = id_instr_q[15:11];
  assign id_funct = id_instr_q[5:0];

`ifndef DPTR_SHIFT_EN
  logic unused_shamt;
  assign unused_shamt = ^id_instr_q[10:6];
`endif

  always_comb begin
    id_legal = 1'b0;
    if (id_op == 6'd0) begin
      case (id_funct)
        F_ADD, F_SUB, F_AND, F_OR, F_NOR, F_SLT: id_legal = 1'b1;
`ifdef DPTR_SHIFT_EN
        F_SLL, F_SRL, F_SRA:                     id_legal = 1'b1;
`endif
        default:                                 id_legal = 1'b0;
      endcase
    end
  end

  // The write-enable is resolved here and carried along the pipe. Forwarding
  // and commit then use a single bit, so illegal ops, rd=0 and out-of-range
  // rd never match a reader.
  assign id_wen = id_valid_q && id_legal && (id_rd != 5'd0) && ({1'b0, id_rd} < REG_N_L);

  // Youngest producer wins: the ALU output of the EX stage, then the EX result
  // register, then the WB register (which is also being committed on this
  // edge if the output transfers), and finally the register file.
  function automatic logic [DATA_W-1:0] read_fwd(input logic [4:0] idx);
    logic [DATA_W-1:0] v;
    if (idx == 5'd0 || {1'b0, idx} >= REG_N_L) begin
      v = '0;
    end else if (ex_wen_q && ex_rd_q == idx) begin
      v = ex_res;
    end else if (wb_wen_q && wb_rd_q == idx) begin
      v = wb_data_q;
    end else if (out_wen_q && out_rd_q == idx) begin
      v = out_data_q;
    end else begin
      v = rf_q[idx[IDX_W-1:0]];
    end
    return v;
  endfunction

  always_comb begin
    id_a = read_fwd(id_rs);
    id_b = read_fwd(id_rt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      ex_funct_q <= '0;
      ex_rd_q    <= '0;
      ex_err_q   <= 1'b0;
      ex_wen_q   <= 1'b0;
`ifdef DPTR_SHIFT_EN
      ex_shamt_q <= '0;
`endif
    end else if (advance) begin
      ex_valid_q <= id_valid_q;
      ex_a_q     <= id_a;
      ex_b_q     <= id_b;
      ex_funct_q <= id_funct;
      ex_rd_q    <= id_rd;
      ex_err_q   <= !id_legal;
      ex_wen_q   <= id_wen;
`ifdef DPTR_SHIFT_EN
      ex_shamt_q <= id_instr_q[10:6];
`endif
    end
  end

  // ------------------------------------------------------------------- EX
  // An illegal op produces 0, so zflag comes out as 1 without a special case.
  always_comb begin
    ex_res = '0;
    if (!ex_err_q) begin
      case (ex_funct_q)
        F_ADD:   ex_res = ex_a_q + ex_b_q;
        F_SUB:   ex_res = ex_a_q - ex_b_q;
        F_AND:   ex_res = ex_a_q & ex_b_q;
        F_OR:    ex_res = ex_a_q | ex_b_q;
        F_NOR:   ex_res = ~(ex_a_q | ex_b_q);
        F_SLT:   ex_res = {{(DATA_W-1){1'b0}}, ($signed(ex_a_q) < $signed(ex_b_q))};
`ifdef DPTR_SHIFT_EN
        // Shifts of DATA_W or more fall out as 0 / sign-fill on their own.
        F_SLL:   ex_res = ex_b_q << ex_shamt_q;
        F_SRL:   ex_res = ex_b_q >> ex_shamt_q;
        F_SRA:   ex_res = $signed(ex_b_q) >>> ex_shamt_q;
`endif
        default: ex_res = '0;
      endcase
    end
  end

  assign ex_z = (ex_res == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_z_q     <= 1'b0;
      wb_rd_q    <= '0;
      wb_err_q   <= 1'b0;
      wb_wen_q   <= 1'b0;
    end else if (advance) begin
      wb_valid_q <= ex_valid_q;
      wb_data_q  <= ex_res;
      wb_z_q     <= ex_z;
      wb_rd_q    <= ex_rd_q;
      wb_err_q   <= ex_err_q;
      wb_wen_q   <= ex_wen_q;
    end
  end

  // ------------------------------------------------------------------- WB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_z_q     <= 1'b0;
      out_rd_q    <= '0;
      out_err_q   <= 1'b0;
      out_wen_q   <= 1'b0;
    end else if (advance) begin
      out_valid_q <= wb_valid_q;
      out_data_q  <= wb_data_q;
      out_z_q     <= wb_z_q;
      out_rd_q    <= wb_rd_q;
      out_err_q   <= wb_err_q;
      out_wen_q   <= wb_wen_q;
    end
  end

  // Commit happens on the output transfer edge, so a stalled result is not
  // yet architectural. Readers still see it through forwarding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_N; i++) begin
        rf_q[i] <= DATA_W'(i);
      end
    end else if (out_fire && out_wen_q) begin
      rf_q[out_rd_q[IDX_W-1:0]] <= out_data_q;
    end
  end

  assign out_valid = out_valid_q;
  assign out_rd    = out_rd_q;
  assign out_data  = out_data_q;
  assign zflag     = out_z_q;
  assign err       = out_err_q;

endmodule

// File: tb/tb_dptr_pipe.sv
// tb/tb_dptr_pipe.sv - scoreboard testbench for dptr_pipe

module tb_dptr_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd;
  logic [31:0] out_data;
  logic        zflag;
  logic        err;

  dptr_pipe #(.DATA_W(32), .REG_N(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_rd    (out_rd),
    .out_data  (out_data),
    .zflag     (zflag),
    .err       (err)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        z;
    logic        e;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_rf [32];
  int          total = 0;
  int          bad = 0;
  int          hold_cnt = 0;
  bit          saw_stall = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn);
    return {op, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt);
    return enc(6'd0, rs, rt, rd, 5'd0, fn);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'(i);
  endtask

  // Sequential reference: each accepted instruction sees every older result.
  task automatic push_expect(input logic [31:0] ins);
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh;
    logic [31:0] a, b, r;
    logic        ok;
    exp_t        e;
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16];
    rd = ins[15:11]; sh = ins[10:6];  fn = ins[5:0];
    a = m_rf[rs]; b = m_rf[rt];
    ok = (op == 6'd0);
    r = 32'd0;
    case (fn)
      F_ADD: r = a + b;
      F_SUB: r = a - b;
      F_AND: r = a & b;
      F_OR:  r = a | b;
      F_NOR: r = ~(a | b);
      F_SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`ifdef DPTR_SHIFT_EN
      6'b000000: r = b << sh;
      6'b000010: r = b >> sh;
      6'b000011: r = $signed(b) >>> sh;
`endif
      default: ok = 1'b0;
    endcase
    if (!ok) r = 32'd0;
    e.rd = rd; e.data = r; e.z = (r == 32'd0); e.e = !ok;
    exp_q.push_back(e);
    if (ok && rd != 5'd0) m_rf[rd] = r;
  endtask

  task automatic drive_slot();
    out_ready = (hold_cnt == 0);
    if (hold_cnt > 0) hold_cnt--;
  endtask

  task automatic issue(input logic [31:0] ins);
    bit done = 1'b0;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      drive_slot();
      in_valid = 1'b1;
      instr = ins;
      #1;
      if (in_ready) begin
        push_expect(ins);
        done = 1'b1;
      end else begin
        saw_stall = 1'b1;
      end
    end
    if (!done) check_val("issue_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      drive_slot();
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) idle(1);
    idle(1);
    check_val("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  // Output monitor: one pop per transfer, compared field by field.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_val("spurious_out", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_val("out_rd",   32'(out_rd), 32'(e.rd));
          check_val("out_data", out_data,    e.data);
          check_val("zflag",    32'(zflag),  32'(e.z));
          check_val("err",      32'(err),    32'(e.e));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] fl [9];
    fl = '{F_ADD, F_SUB, F_AND, F_OR, F_NOR, F_SLT, 6'b000111, 6'b000000, 6'b000010};
    rst = 1'b1; in_valid = 1'b0; instr = 32'd0; out_ready = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_out_rd",    32'(out_rd),    32'd0);
    check_val("rst_out_data",  out_data,       32'd0);
    check_val("rst_zflag",     32'(zflag),     32'd0);
    check_val("rst_err",       32'(err),       32'd0);
    check_val("rst_in_ready",  32'(in_ready),  32'd1);
    @(negedge clk);
    rst = 1'b0;

    // First result: latency of three edges
    issue(rtype(F_ADD, 5'd15, 5'd0, 5'd1));
    idle(2);
    @(negedge clk); drive_slot(); in_valid = 1'b0; #1;
    check_val("lat_early", 32'(out_valid), 32'd0);
    @(negedge clk); drive_slot(); #1;
    check_val("lat_on", 32'(out_valid), 32'd1);
    drain();

    // Back-to-back dependent chain
    issue(rtype(F_ADD, 5'd16, 5'd1, 5'd2));
    issue(rtype(F_SUB, 5'd17, 5'd16, 5'd3));
    issue(rtype(F_SLT, 5'd18, 5'd17, 5'd1));
    drain();

    // Arithmetic / logic values and rd = 0
    issue(rtype(F_SUB, 5'd17, 5'd1, 5'd3));
    issue(rtype(F_AND, 5'd19, 5'd4, 5'd8));
    issue(rtype(F_OR,  5'd23, 5'd6, 5'd7));
    issue(rtype(F_ADD, 5'd0,  5'd1, 5'd2));
    issue(rtype(F_NOR, 5'd24, 5'd0, 5'd0));
    drain();

    // Backpressure with a dependent stream
    saw_stall = 1'b0;
    hold_cnt = 5;
    issue(rtype(F_ADD, 5'd20, 5'd1,  5'd2));
    issue(rtype(F_ADD, 5'd21, 5'd20, 5'd20));
    issue(rtype(F_SUB, 5'd22, 5'd21, 5'd1));
    issue(rtype(F_OR,  5'd25, 5'd22, 5'd8));
    issue(rtype(F_SLT, 5'd26, 5'd1,  5'd22));
    issue(rtype(F_ADD, 5'd27, 5'd26, 5'd25));
    drain();
    check_val("stall_seen", 32'(saw_stall), 32'd1);

    // Illegal instructions leave registers untouched
    issue(rtype(6'b000111, 5'd10, 5'd1, 5'd2));
    issue(enc(6'b000010, 5'd1, 5'd2, 5'd11, 5'd0, F_ADD));
    issue(rtype(F_OR, 5'd28, 5'd10, 5'd0));
    issue(rtype(F_OR, 5'd29, 5'd11, 5'd0));
    issue(enc(6'd0, 5'd0, 5'd5, 5'd12, 5'd2, 6'b000000));
    issue(rtype(F_OR, 5'd30, 5'd12, 5'd0));
    drain();

    // Random stream with random backpressure
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 7) == 0) hold_cnt = $urandom_range(1, 4);
      issue(enc(($urandom_range(0, 9) == 0) ? 6'd1 : 6'd0, 5'($urandom), 5'($urandom),
                5'($urandom), 5'($urandom), fl[$urandom_range(0, 8)]));
    end
    drain();

    // Reset with three instructions in flight
    issue(rtype(F_ADD, 5'd15, 5'd1, 5'd2));
    issue(rtype(F_ADD, 5'd16, 5'd15, 5'd15));
    issue(rtype(F_SUB, 5'd14, 5'd16, 5'd1));
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    model_reset();
    #1;
    check_val("rst_mid_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idle(1);
      #1;
      check_val("post_rst_quiet", 32'(out_valid), 32'd0);
    end
    issue(rtype(F_OR, 5'd30, 5'd15, 5'd0));
    issue(rtype(F_OR, 5'd31, 5'd16, 5'd14));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
